// File: rtl/key_pkg.sv
// Shared types and elaboration-time helpers for the key press detector.
package key_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_DB_PRESS   = 3'd1,
    ST_PRESSED    = 3'd2,
    ST_LONG       = 3'd3,
    ST_DB_RELEASE = 3'd4
  } key_state_e;

  // Clock cycles per millisecond, never below one.
  function automatic int ms_divisor(input int sys_freq);
    return (sys_freq / 1000 < 1) ? 1 : sys_freq / 1000;
  endfunction

  // Bits needed to hold 0..max_val, at least one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: two-flop synchronizer, debounce/hold FSM, registered pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic       i_Sys_clk,
  input  logic       i_Rst,
  input  logic       i_key,
  input  logic       i_ms_tick,
  output logic       o_key_level,
  output logic       o_press_pulse,
  output logic       o_release_pulse,
  output logic       o_short_pulse,
  output logic       o_long_pulse,
  output key_state_e o_state
);

  localparam int DB_W   = cnt_width(DEBOUNCE_MS - 1);
  localparam int HOLD_W = cnt_width(LONG_MS - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);

  logic [1:0]        r_sync;
  key_state_e        r_state;
  logic [DB_W-1:0]   r_db_cnt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_was_long;
  logic              r_key_level;
  logic              r_press_pulse;
  logic              r_release_pulse;
  logic              r_short_pulse;
  logic              r_long_pulse;
  logic              w_pressed;

  // Synchronizer resets to 1 so a reset looks like a released key.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], i_key};
  end

  assign w_pressed = ~r_sync[1];

  // A level change always wins over a same-cycle tick, so a bounce never counts.
  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_state         <= ST_IDLE;
      r_db_cnt        <= '0;
      r_hold_cnt      <= '0;
      r_was_long      <= 1'b0;
      r_key_level     <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_pulse   <= 1'b0;
      r_long_pulse    <= 1'b0;
    end else begin
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_short_pulse   <= 1'b0;
      r_long_pulse    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pressed) begin
            r_state  <= ST_DB_PRESS;
            r_db_cnt <= '0;
          end
        end
        ST_DB_PRESS: begin
          if (!w_pressed) begin
            r_state <= ST_IDLE;
          end else if (i_ms_tick) begin
            if (r_db_cnt == DB_LAST) begin
              r_state       <= ST_PRESSED;
              r_press_pulse <= 1'b1;
              r_hold_cnt    <= '0;
              r_key_level   <= 1'b1;
            end else begin
              r_db_cnt <= r_db_cnt + DB_W'(1);
            end
          end
        end
        ST_PRESSED: begin
          if (!w_pressed) begin
            r_state    <= ST_DB_RELEASE;
            r_was_long <= 1'b0;
            r_db_cnt   <= '0;
          end else if (i_ms_tick) begin
            if (r_hold_cnt == HOLD_LAST) begin
              r_state      <= ST_LONG;
              r_long_pulse <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
            end
          end
        end
        ST_LONG: begin
          if (!w_pressed) begin
            r_state    <= ST_DB_RELEASE;
            r_was_long <= 1'b1;
            r_db_cnt   <= '0;
          end
        end
        ST_DB_RELEASE: begin
          if (w_pressed) begin
            r_state <= r_was_long ? ST_LONG : ST_PRESSED;
          end else if (i_ms_tick) begin
            if (r_db_cnt == DB_LAST) begin
              r_state         <= ST_IDLE;
              r_release_pulse <= 1'b1;
              r_short_pulse   <= ~r_was_long;
              r_key_level     <= 1'b0;
            end else begin
              r_db_cnt <= r_db_cnt + DB_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_key_level     = r_key_level;
  assign o_press_pulse   = r_press_pulse;
  assign o_release_pulse = r_release_pulse;
  assign o_short_pulse   = r_short_pulse;
  assign o_long_pulse    = r_long_pulse;
  assign o_state         = r_state;

endmodule

// File: rtl/key_press_detect.sv
// Multi-key press detector: shared millisecond prescaler feeding KEY_NUM channels.
module key_press_detect
  import key_pkg::*;
#(
  parameter int KEY_NUM     = 4,
  parameter int STS_FREQ    = 125_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic                 i_Sys_clk,
  input  logic                 i_Rst,
  input  logic [KEY_NUM-1:0]   i_key,
  output logic [KEY_NUM-1:0]   o_key_level,
  output logic [KEY_NUM-1:0]   o_press_pulse,
  output logic [KEY_NUM-1:0]   o_release_pulse,
  output logic [KEY_NUM-1:0]   o_short_pulse,
  output logic [KEY_NUM-1:0]   o_long_pulse,
  output logic [KEY_NUM*3-1:0] o_dbg_state
);

  localparam int MS_DIV = ms_divisor(STS_FREQ);
  localparam int PS_W   = cnt_width(MS_DIV - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(MS_DIV - 1);

  logic [PS_W-1:0] r_presc;
  logic            w_ms_tick;

  assign w_ms_tick = (r_presc == PS_LAST);

  always_ff @(posedge i_Sys_clk or posedge i_Rst) begin
    if (i_Rst)          r_presc <= '0;
    else if (w_ms_tick) r_presc <= '0;
    else                r_presc <= r_presc + PS_W'(1);
  end

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_state_e w_state;

    key_debounce_ch #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .LONG_MS     (LONG_MS)
    ) u_ch (
      .i_Sys_clk       (i_Sys_clk),
      .i_Rst           (i_Rst),
      .i_key           (i_key[g]),
      .i_ms_tick       (w_ms_tick),
      .o_key_level     (o_key_level[g]),
      .o_press_pulse   (o_press_pulse[g]),
      .o_release_pulse (o_release_pulse[g]),
      .o_short_pulse   (o_short_pulse[g]),
      .o_long_pulse    (o_long_pulse[g]),
      .o_state         (w_state)
    );

    assign o_dbg_state[g*3 +: 3] = w_state;
  end

endmodule
